// File: rtl/dma_read_engine.sv
// DMA read engine: walks a cache-line range issuing 1- or 4-line read bursts
// under an outstanding-line limit and forwards in-order responses to a consumer.
module dma_read_engine #(
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ctl_start,
    input  logic [41:0]  ctl_addr,
    input  logic [31:0]  ctl_num_lines,
    output logic         st_idle,
    output logic         st_active,
    output logic         st_done,
    output logic         mem_re,
    output logic [41:0]  mem_raddr,
    output logic [1:0]   mem_rlength,
    input  logic         mem_ralmostfull,
    input  logic         mem_rvalid,
    input  logic [511:0] mem_rdata,
    output logic         rx_rvalid,
    output logic [511:0] rx_rdata,
    output logic         rx_ralmostfull
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [41:0]      next_addr_q, next_addr_d;
    logic [31:0]      req_left_q, req_left_d;
    logic [31:0]      rsp_left_q, rsp_left_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic             burst4;
    logic             issue;
    logic             rsp_hit;
    logic [2:0]       burst_len;
    logic [OUT_W:0]   out_after;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        next_addr_d = next_addr_q;
        req_left_d  = req_left_q;

        burst4    = (req_left_q >= 32'd4) && (next_addr_q[1:0] == 2'b00);
        burst_len = burst4 ? 3'd4 : 3'd1;
        out_after = {1'b0, outstanding_q} + (OUT_W+1)'(burst_len);
        issue     = (state_q == S_ISSUE) && !mem_ralmostfull && (req_left_q != 32'd0)
                    && (out_after <= (OUT_W+1)'(MAX_OUTSTANDING));
        // Responses only count while a transfer owns the counters; strays just pass through.
        rsp_hit   = mem_rvalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                    && (outstanding_q != '0);

        rsp_left_d    = rsp_left_q - 32'(rsp_hit);
        outstanding_d = outstanding_q + (issue ? OUT_W'(burst_len) : '0) - OUT_W'(rsp_hit);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctl_start) begin
                    next_addr_d   = ctl_addr;
                    req_left_d    = ctl_num_lines;
                    rsp_left_d    = ctl_num_lines;
                    outstanding_d = '0;
                    state_d       = (ctl_num_lines == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    next_addr_d = next_addr_q + 42'(burst_len);
                    req_left_d  = req_left_q - 32'(burst_len);
                    if (req_left_q == 32'(burst_len)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rsp_left_q == 32'd0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            next_addr_q    <= '0;
            req_left_q     <= '0;
            rsp_left_q     <= '0;
            outstanding_q  <= '0;
            mem_re         <= 1'b0;
            mem_rlength    <= 2'b00;
            rx_rvalid      <= 1'b0;
            rx_ralmostfull <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            next_addr_q    <= next_addr_d;
            req_left_q     <= req_left_d;
            rsp_left_q     <= rsp_left_d;
            outstanding_q  <= outstanding_d;
            mem_re         <= issue;
            rx_rvalid      <= mem_rvalid;
            rx_ralmostfull <= mem_ralmostfull;
            if (issue) mem_rlength <= burst4 ? 2'b11 : 2'b00;
        end
    end

    // NOTE: wide payload registers are qualified by their valids, so they carry no reset.
    always_ff @(posedge clk) begin
        if (issue) mem_raddr <= next_addr_q;
        rx_rdata <= mem_rdata;
    end

    assign st_idle   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign st_active = ~st_idle;
    assign st_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_dma_read_engine.sv
// Bench for dma_read_engine: directed vector table plus random transfers,
// checked against a burst-splitting model and an in-order memory model.
module tb_dma_read_engine;
    localparam int MAXO = 4;
    localparam int TOUT = 3000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ctl_start = 1'b0;
    logic [41:0]  ctl_addr = '0;
    logic [31:0]  ctl_num_lines = '0;
    logic         st_idle, st_active, st_done;
    logic         mem_re;
    logic [41:0]  mem_raddr;
    logic [1:0]   mem_rlength;
    logic         mem_ralmostfull = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [511:0] mem_rdata = '0;
    logic         rx_rvalid;
    logic [511:0] rx_rdata;
    logic         rx_ralmostfull;

    dma_read_engine #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n),
        .ctl_start(ctl_start), .ctl_addr(ctl_addr), .ctl_num_lines(ctl_num_lines),
        .st_idle(st_idle), .st_active(st_active), .st_done(st_done),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rlength(mem_rlength),
        .mem_ralmostfull(mem_ralmostfull), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rx_rvalid(rx_rvalid), .rx_rdata(rx_rdata), .rx_ralmostfull(rx_ralmostfull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] addr;
        logic        ready_unused;
        int          ready;
    } mline_t;

    typedef struct {
        logic [41:0]       addr;
        int                n;
        int                lat;
        int                af;
        bit                restart;
        int                nreq;
        logic [3:0][41:0]  ra;
        logic [3:0][1:0]   rl;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_lat = 2;
    int issued_lines = 0;
    int resp_driven = 0;
    int err_pipe, err_af, err_out, err_stat;
    bit skip_pipe = 1'b1;

    mline_t      mq[$];
    logic [41:0] oreq_addr[$];
    logic [1:0]  oreq_len[$];
    int          oreq_cyc[$];
    logic [511:0] orx[$];
    int          orx_cyc[$];
    logic [41:0] exp_addr[$];
    logic [1:0]  exp_len[$];
    vec_t        vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input logic [41:0] a);
        return {8{{22'd0, a} ^ 64'h5A5A_1234_0F0F_9999}};
    endfunction

    // Splits a range into requests: 4-line bursts only when aligned and enough lines remain.
    function automatic void build_model(input logic [41:0] a, input int n);
        logic [41:0] p;
        int left;
        p = a;
        left = n;
        exp_addr.delete();
        exp_len.delete();
        while (left > 0) begin
            if (left >= 4 && p[1:0] == 2'b00) begin
                exp_addr.push_back(p); exp_len.push_back(2'b11);
                p = p + 42'd4; left -= 4;
            end else begin
                exp_addr.push_back(p); exp_len.push_back(2'b00);
                p = p + 42'd1; left -= 1;
            end
        end
    endfunction

    // One clock: observe outputs 1ns after the edge, then drive the memory response.
    task automatic step();
        logic d_af, d_rv;
        logic [511:0] d_rd;
        int nl;
        d_af = mem_ralmostfull;
        d_rv = mem_rvalid;
        d_rd = mem_rdata;
        @(posedge clk);
        #1;
        cyc++;
        if (!skip_pipe) begin
            if (rx_rvalid !== d_rv || (d_rv && rx_rdata !== d_rd) || rx_ralmostfull !== d_af)
                err_pipe++;
            if (mem_re === 1'b1 && d_af) err_af++;
        end
        if (st_idle !== ~st_active || st_idle === 1'bx) err_stat++;
        if (st_done === 1'b1 && st_idle !== 1'b1) err_stat++;
        if (mem_re === 1'b1) begin
            oreq_addr.push_back(mem_raddr);
            oreq_len.push_back(mem_rlength);
            oreq_cyc.push_back(cyc);
            nl = (mem_rlength == 2'b11) ? 4 : 1;
            for (int k = 0; k < nl; k++) mq.push_back('{mem_raddr + 42'(k), 1'b0, cyc + mem_lat});
            issued_lines += nl;
            if (issued_lines - resp_driven > MAXO) err_out++;
        end
        if (rx_rvalid === 1'b1) begin
            orx.push_back(rx_rdata);
            orx_cyc.push_back(cyc);
        end
        if (mq.size() > 0 && mq[0].ready <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = line_data(mq[0].addr);
            void'(mq.pop_front());
            resp_driven++;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {16{$urandom}};
        end
        if (reset_n) skip_pipe = 1'b0;
    endtask

    task automatic clear_obs();
        oreq_addr.delete(); oreq_len.delete(); oreq_cyc.delete();
        orx.delete(); orx_cyc.delete();
        err_pipe = 0; err_af = 0; err_out = 0; err_stat = 0;
    endtask

    task automatic run_transfer(input string tag, input logic [41:0] a, input int n, input int lat,
                                input int af_hold, input bit restart, input bit rand_af,
                                output int nreq_win);
        bit done;
        int mism;
        mem_lat = lat;
        clear_obs();
        build_model(a, n);
        nreq_win = 0;
        done = 1'b0;
        if (af_hold > 0) mem_ralmostfull = 1'b1;
        ctl_addr = a;
        ctl_num_lines = n;
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        ctl_addr = 42'({$urandom, $urandom});
        ctl_num_lines = $urandom;
        if (n > 0) begin
            check({tag, "_start_clears_done"}, st_done, 1'b0);
            check({tag, "_active_after_start"}, st_active, 1'b1);
        end else begin
            check({tag, "_zero_done_next"}, st_done, 1'b1);
        end
        for (int t = 0; t < TOUT && !done; t++) begin
            if (restart && t == 2) begin
                ctl_start = 1'b1; ctl_addr = 42'h0; ctl_num_lines = 32'd1;
            end else begin
                ctl_start = 1'b0;
            end
            if (rand_af) mem_ralmostfull = ($urandom_range(0, 3) == 0);
            else if (t >= af_hold) mem_ralmostfull = 1'b0;
            step();
            if (t < af_hold && mem_re === 1'b1) nreq_win++;
            if (st_done === 1'b1) done = 1'b1;
        end
        ctl_start = 1'b0;
        mem_ralmostfull = 1'b0;
        check({tag, "_done_reached"}, done, 1'b1);
        check({tag, "_req_count"}, oreq_addr.size(), exp_addr.size());
        mism = 0;
        for (int i = 0; i < oreq_addr.size() && i < exp_addr.size(); i++)
            if (oreq_addr[i] !== exp_addr[i] || oreq_len[i] !== exp_len[i]) mism++;
        check({tag, "_req_list_mism"}, mism, 0);
        check({tag, "_rx_count"}, orx.size(), n);
        mism = 0;
        for (int i = 0; i < orx.size() && i < n; i++)
            if (orx[i] !== line_data(a + 42'(i))) mism++;
        check({tag, "_rx_data_mism"}, mism, 0);
        check({tag, "_mem_drained"}, mq.size(), 0);
        check({tag, "_idle_flag"}, st_idle, 1'b1);
        check({tag, "_pipe_err"}, err_pipe, 0);
        check({tag, "_af_err"}, err_af, 0);
        check({tag, "_outstanding_err"}, err_out, 0);
        check({tag, "_status_err"}, err_stat, 0);
    endtask

    task automatic add_vec(input logic [41:0] addr, input int n, input int lat, input int af,
                           input bit rs, input int nreq,
                           input logic [41:0] a0, input logic [41:0] a1,
                           input logic [41:0] a2, input logic [41:0] a3,
                           input logic [1:0] l0, input logic [1:0] l1,
                           input logic [1:0] l2, input logic [1:0] l3);
        vec_t v;
        v.addr = addr; v.n = n; v.lat = lat; v.af = af; v.restart = rs; v.nreq = nreq;
        v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2; v.ra[3] = a3;
        v.rl[0] = l0; v.rl[1] = l1; v.rl[2] = l2; v.rl[3] = l3;
        vt.push_back(v);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nwin;
        int cnt;
        string tag;

        add_vec(42'h100, 8, 2, 0, 1'b0, 2, 42'h100, 42'h104, 42'h0, 42'h0, 2'd3, 2'd3, 2'd0, 2'd0);
        add_vec(42'h102, 6, 2, 0, 1'b0, 3, 42'h102, 42'h103, 42'h104, 42'h0, 2'd0, 2'd0, 2'd3, 2'd0);
        add_vec(42'h0, 0, 2, 0, 1'b0, 0, 42'h0, 42'h0, 42'h0, 42'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        add_vec(42'h200, 16, 20, 0, 1'b0, 4, 42'h200, 42'h204, 42'h208, 42'h20C, 2'd3, 2'd3, 2'd3, 2'd3);
        add_vec(42'h400, 9, 2, 10, 1'b0, 3, 42'h400, 42'h404, 42'h408, 42'h0, 2'd3, 2'd3, 2'd0, 2'd0);
        add_vec(42'h3FF_FFFF_FFFE, 7, 3, 0, 1'b0, 4, 42'h3FF_FFFF_FFFE, 42'h3FF_FFFF_FFFF,
                42'h0, 42'h4, 2'd0, 2'd0, 2'd3, 2'd0);
        add_vec(42'h300, 12, 3, 0, 1'b1, 3, 42'h300, 42'h304, 42'h308, 42'h0, 2'd3, 2'd3, 2'd3, 2'd0);

        clear_obs();
        repeat (3) step();
        check("rst_idle", st_idle, 1'b1);
        check("rst_active", st_active, 1'b0);
        check("rst_done", st_done, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_rx_rvalid", rx_rvalid, 1'b0);
        check("rst_rx_ralmostfull", rx_ralmostfull, 1'b0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < vt.size(); i++) begin
            tag = $sformatf("v%0d", i);
            run_transfer(tag, vt[i].addr, vt[i].n, vt[i].lat, vt[i].af, vt[i].restart, 1'b0, nwin);
            check({tag, "_nreq_table"}, oreq_addr.size(), vt[i].nreq);
            for (int k = 0; k < vt[i].nreq && k < oreq_addr.size(); k++) begin
                check($sformatf("%s_raddr%0d", tag, k), oreq_addr[k], vt[i].ra[k]);
                check($sformatf("%s_rlen%0d", tag, k), oreq_len[k], vt[i].rl[k]);
            end
            if (vt[i].af > 0) check({tag, "_af_window_req"}, nwin, 0);
            if (vt[i].lat >= 20 && oreq_cyc.size() >= 2 && orx_cyc.size() >= 4)
                check({tag, "_second_req_waits"}, oreq_cyc[1] >= orx_cyc[3], 1'b1);
        end

        // Reset in the middle of a transfer, then stray responses, then a fresh transfer.
        mem_lat = 2;
        clear_obs();
        ctl_addr = 42'h500; ctl_num_lines = 32'd8; ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        for (int t = 0; t < 200 && orx.size() < 2; t++) step();
        check("mid_two_rx", orx.size(), 2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_idle", st_idle, 1'b1);
        check("mid_rst_active", st_active, 1'b0);
        check("mid_rst_done", st_done, 1'b0);
        check("mid_rst_mem_re", mem_re, 1'b0);
        check("mid_rst_rx_rvalid", rx_rvalid, 1'b0);
        skip_pipe = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        cnt = 0;
        err_stat = 0;
        for (int t = 0; t < 200 && mq.size() > 0; t++) begin
            step();
            if (mem_re === 1'b1) cnt++;
        end
        step();
        check("stray_no_req", cnt, 0);
        check("stray_idle", st_idle, 1'b1);
        check("stray_not_done", st_done, 1'b0);
        check("stray_status_err", err_stat, 0);
        check("stray_pipe_err", err_pipe, 0);
        run_transfer("post_rst", 42'h600, 4, 2, 0, 1'b0, 1'b0, nwin);

        for (int r = 0; r < 30; r++) begin
            logic [41:0] ra;
            ra = 42'({$urandom, $urandom});
            if (r % 3 == 0) ra = 42'h3FF_FFFF_FFF0 | 42'($urandom_range(0, 15));
            run_transfer($sformatf("r%0d", r), ra, $urandom_range(0, 24), $urandom_range(1, 6),
                         0, 1'b0, 1'b1, nwin);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
